// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared seven-segment glyph constants and capture FSM states
package seven_segment_pkg;

   // Active-low glyphs, bit0 = segment a ... bit6 = segment g, 0 = lit
   localparam logic [6:0] SEG_0   = 7'h40;
   localparam logic [6:0] SEG_1   = 7'h79;
   localparam logic [6:0] SEG_2   = 7'h24;
   localparam logic [6:0] SEG_3   = 7'h30;
   localparam logic [6:0] SEG_4   = 7'h19;
   localparam logic [6:0] SEG_5   = 7'h12;
   localparam logic [6:0] SEG_6   = 7'h02;
   localparam logic [6:0] SEG_7   = 7'h78;
   localparam logic [6:0] SEG_8   = 7'h00;
   localparam logic [6:0] SEG_9   = 7'h10;
   localparam logic [6:0] SEG_A   = 7'h08;
   localparam logic [6:0] SEG_B   = 7'h03;
   localparam logic [6:0] SEG_C   = 7'h46;
   localparam logic [6:0] SEG_D   = 7'h21;
   localparam logic [6:0] SEG_E   = 7'h06;
   localparam logic [6:0] SEG_F   = 7'h0E;
   // Out-of-range marker the encoder emits for values it cannot show
   localparam logic [6:0] SEG_OOR = 7'b0110110;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_LOCKED = 2'd2
   } cap_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - active-low seven-segment pattern to hex digit decoder
module seg_pattern_decode
   import seven_segment_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] value_o,
   output logic       err_o
);

   // Any pattern that is not one of the sixteen glyphs reads as value 0 with error set
   always_comb begin
      value_o = 4'h0;
      err_o   = 1'b0;
      case (seg_i)
         SEG_0:   value_o = 4'h0;
         SEG_1:   value_o = 4'h1;
         SEG_2:   value_o = 4'h2;
         SEG_3:   value_o = 4'h3;
         SEG_4:   value_o = 4'h4;
         SEG_5:   value_o = 4'h5;
         SEG_6:   value_o = 4'h6;
         SEG_7:   value_o = 4'h7;
         SEG_8:   value_o = 4'h8;
         SEG_9:   value_o = 4'h9;
         SEG_A:   value_o = 4'hA;
         SEG_B:   value_o = 4'hB;
         SEG_C:   value_o = 4'hC;
         SEG_D:   value_o = 4'hD;
         SEG_E:   value_o = 4'hE;
         SEG_F:   value_o = 4'hF;
         default: err_o   = 1'b1;
      endcase
   end

endmodule

// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - recovers digits from a multiplexed active-low seven-segment bus
module seven_segment_reader
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              SEG_IN,
   input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
   output logic [4*NUM_DIGITS-1:0] DIGIT_VALUE,
   output logic [NUM_DIGITS-1:0]   DIGIT_ERR,
   output logic                    FRAME_VALID,
   input  logic                    FRAME_READY,
   output logic [4*NUM_DIGITS-1:0] FRAME_VALUE,
   output logic [NUM_DIGITS-1:0]   FRAME_ERR
);

   localparam int             CW      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

   logic [6:0]                  seg_s1_q, seg_s2_q, prev_seg_q;
   logic [NUM_DIGITS-1:0]       en_s1_q, en_s2_q, prev_en_q;
   cap_state_e                  state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic                        en_one_hot, sample_same, wr_en;
   logic [3:0]                  dec_value;
   logic                        dec_err;
   logic [NUM_DIGITS-1:0][3:0]  digit_value_q, digit_value_d;
   logic [NUM_DIGITS-1:0]       digit_err_q, digit_err_d;
   logic [NUM_DIGITS-1:0]       seen_q, seen_d;
   logic                        frame_valid_q, frame_valid_d;
   logic [NUM_DIGITS-1:0][3:0]  frame_value_q, frame_value_d;
   logic [NUM_DIGITS-1:0]       frame_err_q, frame_err_d;

   // Two-flop synchronizer on the external bus; everything downstream uses stage two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_s1_q <= '0;
         seg_s2_q <= '0;
         en_s1_q  <= '0;
         en_s2_q  <= '0;
      end else begin
         seg_s1_q <= SEG_IN;
         seg_s2_q <= seg_s1_q;
         en_s1_q  <= DIGIT_EN;
         en_s2_q  <= en_s1_q;
      end
   end

   seg_pattern_decode u_decode (
      .seg_i   (seg_s2_q),
      .value_o (dec_value),
      .err_o   (dec_err)
   );

   // Stability counting: a digit is written once, on the cycle its run length reaches the threshold
   always_comb begin
      en_one_hot  = (en_s2_q != '0) && ((en_s2_q & (en_s2_q - NUM_DIGITS'(1))) == '0);
      sample_same = (seg_s2_q == prev_seg_q) && (en_s2_q == prev_en_q);
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_en       = 1'b0;
      if (!en_one_hot) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (state_q == ST_IDLE || !sample_same) begin
         state_d = ST_COUNT;
         cnt_d   = CW'(1);
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CW'(1);
      end
      // A locked, unchanged sample sits at the saturated count and must not rewrite
      if (en_one_hot && cnt_d == CNT_MAX && !(state_q == ST_LOCKED && sample_same)) begin
         wr_en   = 1'b1;
         state_d = ST_LOCKED;
      end
   end

   // Capture FSM state, run counter and the previous synchronized sample
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         prev_seg_q <= '0;
         prev_en_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prev_seg_q <= seg_s2_q;
         prev_en_q  <= en_s2_q;
      end
   end

   // Digit write plus single-entry frame holding register; a frame includes a same-cycle digit write
   always_comb begin
      digit_value_d = digit_value_q;
      digit_err_d   = digit_err_q;
      seen_d        = seen_q;
      frame_valid_d = frame_valid_q;
      frame_value_d = frame_value_q;
      frame_err_d   = frame_err_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (wr_en && en_s2_q[i]) begin
            digit_value_d[i] = dec_value;
            digit_err_d[i]   = dec_err;
            seen_d[i]        = 1'b1;
         end
      end
      if ((&seen_d) && (!frame_valid_q || FRAME_READY)) begin
         frame_valid_d = 1'b1;
         frame_value_d = digit_value_d;
         frame_err_d   = digit_err_d;
         seen_d        = '0;
      end else if (frame_valid_q && FRAME_READY) begin
         frame_valid_d = 1'b0;
      end
   end

   // Registered digit and frame state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digit_value_q <= '0;
         digit_err_q   <= '0;
         seen_q        <= '0;
         frame_valid_q <= 1'b0;
         frame_value_q <= '0;
         frame_err_q   <= '0;
      end else begin
         digit_value_q <= digit_value_d;
         digit_err_q   <= digit_err_d;
         seen_q        <= seen_d;
         frame_valid_q <= frame_valid_d;
         frame_value_q <= frame_value_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign DIGIT_VALUE = digit_value_q;
   assign DIGIT_ERR   = digit_err_q;
   assign FRAME_VALID = frame_valid_q;
   assign FRAME_VALUE = frame_value_q;
   assign FRAME_ERR   = frame_err_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb/tb_seven_segment_reader.sv - randomized and directed bench with a behavioural reference model
module tb_seven_segment_reader;
   import seven_segment_pkg::*;

   localparam int N = 4;
   localparam int S = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [6:0]    seg_in = 7'h7F;
   logic [N-1:0]  digit_en = '0;
   logic          frame_ready = 1'b1;
   logic [4*N-1:0] digit_value, frame_value;
   logic [N-1:0]  digit_err, frame_err;
   logic          frame_valid;

   int n_checks = 0;
   int n_errors = 0;

   seven_segment_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
      .clk         (clk),
      .reset       (reset),
      .SEG_IN      (seg_in),
      .DIGIT_EN    (digit_en),
      .DIGIT_VALUE (digit_value),
      .DIGIT_ERR   (digit_err),
      .FRAME_VALID (frame_valid),
      .FRAME_READY (frame_ready),
      .FRAME_VALUE (frame_value),
      .FRAME_ERR   (frame_err)
   );

   always #5 clk = ~clk;

   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: the bus is seen two cycles late, a digit is accepted when a run of
   // identical one-hot samples reaches exactly S, and one frame can be held at a time.
   logic [6:0]     m_s1_seg, m_s2_seg;
   logic [N-1:0]   m_s1_en, m_s2_en;
   logic [6+N:0]   m_last;
   int             m_run;
   logic [4*N-1:0] m_dval, m_fval;
   logic [N-1:0]   m_derr, m_ferr, m_seen;
   logic           m_fv;
   logic [3:0]     r_val;
   logic           r_err;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_s1_seg = '0; m_s2_seg = '0; m_s1_en = '0; m_s2_en = '0;
         m_last = '0; m_run = 0; m_dval = '0; m_derr = '0; m_seen = '0;
         m_fv = 1'b0; m_fval = '0; m_ferr = '0;
      end else begin
         if ($countones(m_s2_en) == 1) begin
            if (m_run > 0 && {m_s2_seg, m_s2_en} == m_last) m_run++;
            else m_run = 1;
            if (m_run == S) begin
               r_val = 4'h0;
               r_err = 1'b1;
               for (int g = 0; g < 16; g++)
                  if (glyph[g] == m_s2_seg) begin r_val = 4'(g); r_err = 1'b0; end
               for (int d = 0; d < N; d++)
                  if (m_s2_en[d]) begin
                     m_dval[4*d +: 4] = r_val;
                     m_derr[d] = r_err;
                     m_seen[d] = 1'b1;
                  end
            end
         end else begin
            m_run = 0;
         end
         m_last = {m_s2_seg, m_s2_en};
         if (m_seen == {N{1'b1}} && (!m_fv || frame_ready)) begin
            m_fv = 1'b1; m_fval = m_dval; m_ferr = m_derr; m_seen = '0;
         end else if (m_fv && frame_ready) begin
            m_fv = 1'b0;
         end
         m_s2_seg = m_s1_seg; m_s2_en = m_s1_en;
         m_s1_seg = seg_in;   m_s1_en = digit_en;
      end
   end

   int             xfer_cnt = 0;
   logic [4*N-1:0] xfer_val;
   logic [N-1:0]   xfer_err;

   // One clock: note a handshake about to happen, then compare all outputs on the falling edge
   task automatic tick();
      if (frame_valid && frame_ready && !reset) begin
         xfer_cnt++;
         xfer_val = frame_value;
         xfer_err = frame_err;
      end
      @(negedge clk);
      check("digit_value", 32'(digit_value), 32'(m_dval));
      check("digit_err",   32'(digit_err),   32'(m_derr));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("frame_value", 32'(frame_value), 32'(m_fval));
      check("frame_err",   32'(frame_err),   32'(m_ferr));
   endtask

   task automatic drive(input logic [6:0] seg, input logic [N-1:0] en, input int cycles);
      seg_in = seg;
      digit_en = en;
      for (int c = 0; c < cycles; c++) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   int x0;

   initial begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) tick();
      reset = 1'b0;
      tick();
      check("rst_dval", 32'(digit_value), 32'h0);
      check("rst_fv",   32'(frame_valid), 32'h0);

      // Full frame 4321 with READY high
      frame_ready = 1'b1;
      xfer_cnt = 0;
      drive(7'h79, 4'b0001, 20);
      drive(7'h24, 4'b0010, 20);
      drive(7'h30, 4'b0100, 20);
      drive(7'h19, 4'b1000, 20);
      drive(7'h7F, 4'b0000, 5);
      check("f1_count", 32'(xfer_cnt), 32'd1);
      check("f1_value", 32'(xfer_val), 32'h4321);
      check("f1_err",   32'(xfer_err), 32'h0);

      // Exactly S cycles accepted, S-1 ignored
      drive(7'h46, 4'b0001, S);
      drive(7'h79, 4'b0001, S - 1);
      drive(7'h7F, 4'b0000, 6);
      check("win_digit0", 32'(digit_value[3:0]), 32'hC);

      // Out-of-range marker on digit 2
      x0 = xfer_cnt;
      drive(SEG_OOR, 4'b0100, 12);
      check("oor_err",   32'(digit_err[2]), 32'h1);
      check("oor_value", 32'(digit_value[11:8]), 32'h0);
      drive(7'h24, 4'b0010, 12);
      drive(7'h19, 4'b1000, 12);
      drive(7'h7F, 4'b0000, 4);
      check("oor_count",  32'(xfer_cnt - x0), 32'd1);
      check("oor_fvalue", 32'(xfer_val), 32'h402C);
      check("oor_ferr",   32'(xfer_err), 32'h4);

      // Non-one-hot enables write nothing
      drive(7'h40, 4'b0011, 15);
      check("multi_dval",  32'(digit_value), 32'h402C);
      check("multi_state", 32'(dut.state_q), 32'(ST_IDLE));
      drive(7'h40, 4'b0000, 15);
      check("zero_dval",  32'(digit_value), 32'h402C);
      check("zero_state", 32'(dut.state_q), 32'(ST_IDLE));

      // Three frames while stalled, then release
      frame_ready = 1'b0;
      x0 = xfer_cnt;
      drive(7'h12, 4'b0001, 12); drive(7'h02, 4'b0010, 12);
      drive(7'h78, 4'b0100, 12); drive(7'h00, 4'b1000, 12);
      check("stall_fv1", 32'(frame_valid), 32'h1);
      check("stall_fa",  32'(frame_value), 32'h8765);
      drive(7'h10, 4'b0001, 12); drive(7'h08, 4'b0010, 12);
      drive(7'h03, 4'b0100, 12); drive(7'h21, 4'b1000, 12);
      drive(7'h06, 4'b0001, 12); drive(7'h0E, 4'b0010, 12);
      drive(7'h40, 4'b0100, 12); drive(7'h79, 4'b1000, 12);
      check("stall_hold", 32'(frame_value), 32'h8765);
      check("stall_none", 32'(xfer_cnt - x0), 32'd0);
      frame_ready = 1'b1;
      tick();
      check("release_xfer",  32'(xfer_val), 32'h8765);
      check("release_fv",    32'(frame_valid), 32'h1);
      check("release_latest", 32'(frame_value), 32'h10FE);
      tick();
      check("release_drain", 32'(frame_valid), 32'h0);

      // Reset mid-count with digits partly seen
      drive(7'h79, 4'b0001, 12);
      drive(7'h24, 4'b0010, 12);
      drive(7'h30, 4'b0100, 4);
      reset = 1'b1;
      #1;
      check("mid_rst_dval", 32'(digit_value), 32'h0);
      check("mid_rst_derr", 32'(digit_err),   32'h0);
      check("mid_rst_fv",   32'(frame_valid), 32'h0);
      check("mid_rst_fval", 32'(frame_value), 32'h0);
      check("mid_rst_ferr", 32'(frame_err),   32'h0);
      tick(); tick();
      reset = 1'b0;
      x0 = xfer_cnt;
      drive(7'h30, 4'b0100, 12);
      drive(7'h19, 4'b1000, 12);
      drive(7'h7F, 4'b0000, 4);
      check("post_rst_partial", 32'(xfer_cnt - x0), 32'd0);
      drive(7'h12, 4'b0001, 12);
      drive(7'h02, 4'b0010, 12);
      drive(7'h7F, 4'b0000, 4);
      check("post_rst_count", 32'(xfer_cnt - x0), 32'd1);
      check("post_rst_frame", 32'(xfer_val), 32'h4365);

      // Randomized segments against the model
      for (int k = 0; k < 300; k++) begin
         int r, p;
         logic [6:0] sg;
         logic [N-1:0] en;
         r = $urandom_range(0, 19);
         if (r < 16) sg = glyph[r];
         else if (r == 16) sg = SEG_OOR;
         else sg = 7'($urandom);
         p = $urandom_range(0, 9);
         if (p < 8) en = N'(1) << $urandom_range(0, N - 1);
         else if (p == 8) en = '0;
         else en = N'($urandom);
         frame_ready = ($urandom_range(0, 2) != 0);
         drive(sg, en, $urandom_range(1, 20));
      end
      frame_ready = 1'b1;
      drive(7'h7F, 4'b0000, 6);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seven_segment_reader.md
# seven_segment_reader

Reverse direction of the team's seven-segment encoder: samples a multiplexed, active-low seven-segment bus and recovers the hex digit shown on each position. Used as an on-chip monitor / loopback checker behind the display driver and for reading external displays. Each digit pattern must be stable for a configurable number of cycles before it is accepted. Completed frames of all digits are handed downstream over a valid/ready handshake.

## Interface
- NUM_DIGITS, 4: number of multiplexed digit positions (≥1).
- STABLE_CYCLES, 8: consecutive identical synchronized samples required to accept a digit (≥1).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- SEG_IN  in  7  segment lines, bit0=a … bit6=g, 0 = lit.
- DIGIT_EN  in  NUM_DIGITS  one-hot active-high digit select.
- DIGIT_VALUE  out  4*NUM_DIGITS  live accepted value per digit, digit i at [4i+3:4i].
- DIGIT_ERR  out  NUM_DIGITS  live: last accepted pattern of digit i was not a legal 0–F glyph.
- FRAME_VALID  out  1  FRAME_VALUE/FRAME_ERR hold a complete frame.
- FRAME_READY  in  1  downstream accepts the frame.
- FRAME_VALUE  out  4*NUM_DIGITS  frame snapshot of DIGIT_VALUE.
- FRAME_ERR  out  NUM_DIGITS  frame snapshot of DIGIT_ERR.

## Operation
- SEG_IN and DIGIT_EN pass through a 2-flop synchronizer; all logic uses the synchronized values.
- Decode (active-low): 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9, 0x08→A, 0x03→B, 0x46→C, 0x21→D, 0x06→E, 0x0E→F. Any other pattern, including the out-of-range marker 0x36: value 0, error 1.
- Capture FSM, states IDLE / COUNT / LOCKED:
  - IDLE: DIGIT_EN not one-hot (zero or multiple bits); counter 0. Valid one-hot → COUNT, counter 1.
  - COUNT: sample equal to previous (SEG and DIGIT_EN) → counter+1; when counter reaches STABLE_CYCLES, write decoded value/error into the selected digit, set its seen bit, → LOCKED. Sample differs → counter 1, stay COUNT (or IDLE if not one-hot).
  - LOCKED: no rewrite while the sample is unchanged; any change → COUNT/IDLE as above.
- Counter width clog2(STABLE_CYCLES+1); saturates, never wraps.
- Frame: seen mask of NUM_DIGITS bits. When all bits are set and the holding register is free (FRAME_VALID=0, or FRAME_READY=1 this cycle), snapshot DIGIT_VALUE/DIGIT_ERR (including a write in the same cycle) into FRAME_*, set FRAME_VALID, clear the seen mask.
- If the holding register is busy, the seen mask stays full and digits keep updating. The load occurs on the first free cycle with the latest values. No frame is queued beyond one.
- FRAME_VALUE/FRAME_ERR are stable while FRAME_VALID=1 and FRAME_READY=0.

## Timing
- Reset (async assert, sync deassert handled externally): DIGIT_VALUE=0, DIGIT_ERR=0, FRAME_VALID=0, FRAME_VALUE=0, FRAME_ERR=0, seen mask 0, FSM IDLE, synchronizers 0.
- Pins stable from edge E: the digit register updates at edge E+1+STABLE_CYCLES. Visible on DIGIT_VALUE after that edge.
- The frame loads on the same edge as the completing digit write if the holding register is free. FRAME_VALID rises after that edge.
- Handshake: transfer on an edge where FRAME_VALID&FRAME_READY. A simultaneous transfer and frame completion loads the new frame with FRAME_VALID staying 1.
- Reset mid-count or mid-frame: all state is lost immediately, and the partial frame is discarded.

## Structure
- Package seven_segment_pkg: SEG_0..SEG_F and SEG_OOR (7'b0110110) constants, FSM state enum, shared with the encoder side.
- Sub-module seg_pattern_decode: combinational 7-bit pattern → {err, value[3:0]}; single instance on the synchronized bus.

## Test plan
- NUM_DIGITS=4, STABLE_CYCLES=8; drive digits 0..3 with 0x79,0x24,0x30,0x19, each held 20 cycles → FRAME_VALUE=16'h4321, FRAME_ERR=0, one FRAME_VALID with READY=1.
- Hold 0x46 on digit 0 for exactly 8 cycles (STABLE_CYCLES) then 7 cycles → only the first window updates digit 0 to C; the 7-cycle window is ignored.
- Drive 0x36 on digit 2 → DIGIT_ERR[2]=1, digit value 0, FRAME_ERR[2]=1 in the next frame.
- DIGIT_EN=4'b0011 or 0 with any SEG_IN → no digit written, FSM IDLE.
- FRAME_READY=0 for three full frames, then 1 → FRAME_VALUE unchanged while stalled. After the handshake, a frame with the latest digits loads on the next free edge.
- Assert reset mid-count with digits partly seen → all outputs 0. The first frame after reset requires all four digits again.
